msrv32_reg_writeback_unit: RTL and testbench

- Write side of the integer register file. Produces the file's write enable, destination address and write data.
- Sources: single-cycle ALU results, and load data returned by the data-memory interface.
- Load data is aligned and sign- or zero-extended before write-back.
- Tracks one outstanding load, with a timeout and misalignment error reporting.
- Asserts a stall to the front end while a load is pending.

---
 rtl/msrv32_reg_writeback_unit.sv | 173 +++++++++++++++++
 tb/tb_msrv32_reg_writeback_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_reg_writeback_unit.sv
// Register-file write side: merges single-cycle ALU results with aligned load data,
// tracking one outstanding load with timeout and misalignment/illegal-funct3 errors.
module msrv32_reg_writeback_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        alu_valid_in,
    input  logic [4:0]  alu_rd_addr_in,
    input  logic [31:0] alu_result_in,
    input  logic        load_issue_in,
    input  logic [4:0]  load_rd_addr_in,
    input  logic [2:0]  load_funct3_in,
    input  logic [1:0]  load_offset_in,
    input  logic        dmem_rvalid_in,
    input  logic [31:0] dmem_rdata_in,
    input  logic        err_clr_in,
    output logic        wr_en_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_out,
    output logic        stall_out,
    output logic        load_err_out,
    output logic [1:0]  err_code_out
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        ERR       = 2'd2
    } state_t;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;
    localparam logic [CNT_W:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[CNT_W:0];
    localparam logic [CNT_W:0] CNT_ONE       = {{CNT_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        ld_rd_q, ld_rd_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_off_q, ld_off_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              wr_en_q, wr_en_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic [31:0]       rd_q, rd_d;

    logic [CNT_W:0]    cnt_inc;
    logic [31:0]       byte_sh, half_sh, load_data;

    assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;

    // Memory returns a naturally aligned word; shift the addressed lane down to bit 0.
    assign byte_sh = dmem_rdata_in >> {ld_off_q, 3'b000};
    assign half_sh = dmem_rdata_in >> {ld_off_q[1], 4'b0000};

    always_comb begin
        load_data = dmem_rdata_in;
        case (ld_f3_q)
            3'b000:  load_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b100:  load_data = {24'd0, byte_sh[7:0]};
            3'b001:  load_data = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b101:  load_data = {16'd0, half_sh[15:0]};
            default: load_data = dmem_rdata_in;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_rd_d    = ld_rd_q;
        ld_f3_d    = ld_f3_q;
        ld_off_d   = ld_off_q;
        err_code_d = err_code_q;
        wr_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_d       = rd_q;
        case (state_q)
            IDLE: begin
                if (alu_valid_in) begin
                    wr_en_d   = |alu_rd_addr_in;
                    rd_addr_d = alu_rd_addr_in;
                    rd_d      = alu_result_in;
                end
                if (load_issue_in) begin
                    ld_rd_d  = load_rd_addr_in;
                    ld_f3_d  = load_funct3_in;
                    ld_off_d = load_offset_in;
                    case (load_funct3_in)
                        3'b011, 3'b110, 3'b111: begin
                            state_d    = ERR;
                            err_code_d = ERR_FUNCT3;
                        end
                        3'b001, 3'b101: begin
                            if (load_offset_in[0]) begin
                                state_d    = ERR;
                                err_code_d = ERR_MISALIGN;
                            end else begin
                                state_d = LOAD_WAIT;
                                cnt_d   = '0;
                            end
                        end
                        3'b010: begin
                            if (load_offset_in != 2'b00) begin
                                state_d    = ERR;
                                err_code_d = ERR_MISALIGN;
                            end else begin
                                state_d = LOAD_WAIT;
                                cnt_d   = '0;
                            end
                        end
                        default: begin
                            state_d = LOAD_WAIT;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end
            LOAD_WAIT: begin
                // A response wins over a timeout expiring in the same cycle.
                if (dmem_rvalid_in) begin
                    state_d   = IDLE;
                    wr_en_d   = |ld_rd_q;
                    rd_addr_d = ld_rd_q;
                    rd_d      = load_data;
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                    if (cnt_inc == TIMEOUT_LIMIT) begin
                        state_d    = ERR;
                        err_code_d = ERR_TIMEOUT;
                    end
                end
            end
            ERR: begin
                if (err_clr_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ld_rd_q    <= '0;
            ld_f3_q    <= '0;
            ld_off_q   <= '0;
            err_code_q <= '0;
            wr_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_rd_q    <= ld_rd_d;
            ld_f3_q    <= ld_f3_d;
            ld_off_q   <= ld_off_d;
            err_code_q <= err_code_d;
            wr_en_q    <= wr_en_d;
            rd_addr_q  <= rd_addr_d;
            rd_q       <= rd_d;
        end
    end

    assign wr_en_out    = wr_en_q;
    assign rd_addr_out  = rd_addr_q;
    assign rd_out       = rd_q;
    assign stall_out    = (state_q != IDLE);
    assign load_err_out = (state_q == ERR);
    assign err_code_out = err_code_q;

endmodule

// File: tb/tb_msrv32_reg_writeback_unit.sv
// Self-checking bench for msrv32_reg_writeback_unit; expected writes are queued as
// {rd_addr, data} when stimulus is driven and popped when wr_en_out fires.
module tb_msrv32_reg_writeback_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [31:0] alu_res = '0;
    logic        ld_issue = 1'b0;
    logic [4:0]  ld_rd = '0;
    logic [2:0]  ld_f3 = '0;
    logic [1:0]  ld_off = '0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic        err_clr = 1'b0;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        stall;
    logic        load_err;
    logic [1:0]  err_code;

    logic [36:0] exp_q[$];
    logic [36:0] exp_e;
    int vectors = 0;
    int miscompares = 0;

    msrv32_reg_writeback_unit #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
        .ms_riscv32_mp_clk_in(clk),
        .ms_riscv32_mp_rst_in(rst),
        .alu_valid_in(alu_valid),
        .alu_rd_addr_in(alu_rd),
        .alu_result_in(alu_res),
        .load_issue_in(ld_issue),
        .load_rd_addr_in(ld_rd),
        .load_funct3_in(ld_f3),
        .load_offset_in(ld_off),
        .dmem_rvalid_in(rvalid),
        .dmem_rdata_in(rdata),
        .err_clr_in(err_clr),
        .wr_en_out(wr_en),
        .rd_addr_out(rd_addr),
        .rd_out(rd_data),
        .stall_out(stall),
        .load_err_out(load_err),
        .err_code_out(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_valid = 1'b0; ld_issue = 1'b0; rvalid = 1'b0; err_clr = 1'b0;
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    task automatic test_reset();
        vectors++;
        if ({wr_en, rd_addr, rd_data, stall, load_err, err_code} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {wr_en, rd_addr, rd_data, stall, load_err, err_code});
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_alu(input logic [4:0] rd, input logic [31:0] val);
        alu_valid = 1'b1; alu_rd = rd; alu_res = val;
        if (rd != 0) exp_q.push_back({rd, val});
        step();
        clear_inputs();
        vectors++;
        if (wr_en !== (rd != 0)) begin
            miscompares++;
            $display("FAIL alu_wr_en rd=%0d: got %b expected %b", rd, wr_en, rd != 0);
        end
        if (wr_en === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL alu_unexpected_write: got %h expected none", {rd_addr, rd_data});
            end else begin
                exp_e = exp_q.pop_front();
                if ({rd_addr, rd_data} !== exp_e) begin
                    miscompares++;
                    $display("FAIL alu_write: got %h expected %h", {rd_addr, rd_data}, exp_e);
                end
            end
        end
        step();
        vectors++;
        if (wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_pulse: got %b expected 0", wr_en);
        end
    endtask

    // Issue a legal load, wait `delay` cycles, return rdata, and check the single write.
    task automatic test_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                             input logic [31:0] word, input logic [31:0] exp_data, input int delay);
        ld_issue = 1'b1; ld_f3 = f3; ld_off = off; ld_rd = rd;
        if (rd != 0) exp_q.push_back({rd, exp_data});
        step();
        clear_inputs();
        for (int i = 0; i < delay; i++) begin
            vectors++;
            if (stall !== 1'b1 || wr_en !== 1'b0) begin
                miscompares++;
                $display("FAIL load_wait: got stall=%b wr_en=%b expected stall=1 wr_en=0", stall, wr_en);
            end
            alu_valid = 1'b1; alu_rd = 5'd9; alu_res = $urandom;
            ld_issue = 1'b1; ld_f3 = 3'b011;
            step();
            clear_inputs();
        end
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL load_stall_rvalid_cycle: got %b expected 1", stall);
        end
        rvalid = 1'b1; rdata = word;
        step();
        clear_inputs();
        vectors++;
        if (wr_en !== (rd != 0) || stall !== 1'b0) begin
            miscompares++;
            $display("FAIL load_done: got wr_en=%b stall=%b expected wr_en=%b stall=0", wr_en, stall, rd != 0);
        end
        if (wr_en === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL load_unexpected_write: got %h expected none", {rd_addr, rd_data});
            end else begin
                exp_e = exp_q.pop_front();
                if ({rd_addr, rd_data} !== exp_e) begin
                    miscompares++;
                    $display("FAIL load_write: got %h expected %h", {rd_addr, rd_data}, exp_e);
                end
            end
        end
        rvalid = 1'b1;
        step();
        clear_inputs();
        vectors++;
        if (wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL load_single_write: got %b expected 0", wr_en);
        end
    endtask

    task automatic test_error(input logic [2:0] f3, input logic [1:0] off, input logic [1:0] code);
        ld_issue = 1'b1; ld_f3 = f3; ld_off = off; ld_rd = 5'd3;
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (load_err !== 1'b1 || err_code !== code || wr_en !== 1'b0 || stall !== 1'b1) begin
                miscompares++;
                $display("FAIL error_state f3=%b: got err=%b code=%b wr_en=%b stall=%b expected 1 %b 0 1",
                         f3, load_err, err_code, wr_en, stall, code);
            end
            rvalid = 1'b1; alu_valid = 1'b1; alu_rd = 5'd2;
            step();
            clear_inputs();
        end
        err_clr = 1'b1;
        step();
        clear_inputs();
        vectors++;
        if (stall !== 1'b0 || load_err !== 1'b0 || err_code !== code || wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL error_clear: got stall=%b err=%b code=%b wr_en=%b expected 0 0 %b 0",
                     stall, load_err, err_code, wr_en, code);
        end
    endtask

    task automatic test_timeout();
        ld_issue = 1'b1; ld_f3 = 3'b010; ld_off = 2'b00; ld_rd = 5'd4;
        step();
        clear_inputs();
        for (int i = 0; i < 7; i++) begin
            step();
            vectors++;
            if (load_err !== 1'b0 || stall !== 1'b1 || wr_en !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_early cycle %0d: got err=%b stall=%b wr_en=%b expected 0 1 0",
                         i, load_err, stall, wr_en);
            end
        end
        step();
        vectors++;
        if (load_err !== 1'b1 || err_code !== 2'b10 || wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout: got err=%b code=%b wr_en=%b expected 1 10 0", load_err, err_code, wr_en);
        end
        err_clr = 1'b1;
        step();
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        alu_valid = 1'b1; alu_rd = 5'd6; alu_res = 32'hCAFE_F00D;
        ld_issue = 1'b1; ld_f3 = 3'b101; ld_off = 2'b10; ld_rd = 5'd8;
        exp_q.push_back({5'd6, 32'hCAFE_F00D});
        exp_q.push_back({5'd8, 32'h0000_BEEF});
        step();
        clear_inputs();
        rvalid = 1'b1; rdata = 32'hBEEF_1234;
        vectors++;
        exp_e = exp_q.pop_front();
        if (wr_en !== 1'b1 || {rd_addr, rd_data} !== exp_e || stall !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_alu: got wr_en=%b %h stall=%b expected 1 %h 1", wr_en, {rd_addr, rd_data}, stall, exp_e);
        end
        step();
        clear_inputs();
        vectors++;
        exp_e = exp_q.pop_front();
        if (wr_en !== 1'b1 || {rd_addr, rd_data} !== exp_e) begin
            miscompares++;
            $display("FAIL simul_load: got wr_en=%b %h expected 1 %h", wr_en, {rd_addr, rd_data}, exp_e);
        end
        step();
    endtask

    task automatic test_reset_mid_load();
        ld_issue = 1'b1; ld_f3 = 3'b010; ld_off = 2'b00; ld_rd = 5'd12;
        step();
        clear_inputs();
        step();
        rst = 1'b1;
        #1;
        vectors++;
        if ({wr_en, rd_addr, rd_data, stall, load_err, err_code} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_mid_load: got %h expected 0", {wr_en, rd_addr, rd_data, stall, load_err, err_code});
        end
        step();
        rst = 1'b0;
        rvalid = 1'b1; rdata = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (wr_en !== 1'b0 || stall !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_abandon: got wr_en=%b stall=%b expected 0 0", wr_en, stall);
            end
        end
        clear_inputs();
    endtask

    task automatic test_random_loads();
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] w;
        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(0, 4))
                0: f3 = 3'b000;
                1: f3 = 3'b100;
                2: f3 = 3'b001;
                3: f3 = 3'b101;
                default: f3 = 3'b010;
            endcase
            off = 2'($urandom_range(0, 3));
            if (f3 == 3'b010) off = 2'b00;
            else if (f3[1:0] == 2'b01) off[0] = 1'b0;
            w = $urandom;
            test_load(f3, off, 5'($urandom_range(0, 31)), w, model_load(f3, off, w), $urandom_range(0, 5));
        end
    endtask

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_alu(5'd5, 32'h1234_5678);
        test_alu(5'd0, 32'hDEAD_BEEF);
        test_load(3'b000, 2'd3, 5'd7, 32'h80FF_0000, 32'hFFFF_FF80, 3);
        test_load(3'b100, 2'd3, 5'd7, 32'h80FF_0000, 32'h0000_0080, 3);
        test_load(3'b101, 2'd2, 5'd10, 32'hBEEF_1234, 32'h0000_BEEF, 0);
        test_load(3'b001, 2'd2, 5'd11, 32'h8001_0000, 32'hFFFF_8001, 2);
        test_load(3'b010, 2'd0, 5'd0, 32'h5555_AAAA, 32'h5555_AAAA, 1);
        test_load(3'b010, 2'd0, 5'd13, 32'h0BAD_F00D, 32'h0BAD_F00D, 7);
        test_error(3'b010, 2'd1, 2'b01);
        test_error(3'b001, 2'd3, 2'b01);
        test_error(3'b110, 2'd0, 2'b11);
        test_timeout();
        test_simultaneous();
        test_random_loads();
        test_reset_mid_load();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
